unidade_controle_param: RTL and testbench

UNIDADE_CONTROLE_PARAM -- requirements
Module: unidade_controle_param

---
 rtl/uc_param_pkg.sv | 38 +++
 rtl/contador_limite.sv | 25 ++
 rtl/unidade_controle_param.sv | 164 ++++++++++++++++
 tb/tb_unidade_controle_param.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uc_param_pkg.sv
// Shared state codes, display message codes and parameter defaults for the
// game control unit and its timers.
package uc_param_pkg;

  typedef enum logic [3:0] {
    inicial          = 4'h0,
    preparacao       = 4'h1,
    inicia_rodada    = 4'h2,
    espera_jogada    = 4'h3,
    registra         = 4'h4,
    comparacao       = 4'h5,
    conta_acerto     = 4'h6,
    pisca_on         = 4'h8,
    testa_fim        = 4'h9,
    final_com_acerto = 4'hA,
    proxima_rodada   = 4'hB,
    pisca_off        = 4'hC,
    estado_timeout   = 4'hE
  } estado_t;

  localparam logic [1:0] DISP_PREPARACAO = 2'b00;
  localparam logic [1:0] DISP_ACERTO     = 2'b01;
  localparam logic [1:0] DISP_TIMEOUT    = 2'b10;
  localparam logic [1:0] DISP_JOGO       = 2'b11;

  localparam int N_SEQ_PADRAO      = 16;
  localparam int N_ACERTOS_PADRAO  = 2;
  localparam int N_PISCADAS_PADRAO = 3;
  localparam int T_ON_PADRAO       = 500;
  localparam int T_OFF_PADRAO      = 500;
  localparam int T_LIMITE_PADRAO   = 5000;

  // Bits needed to hold 0..limite-1, never less than one.
  function automatic int larguraPara(input int limite);
    return (limite > 1) ? $clog2(limite) : 1;
  endfunction

endpackage

// File: rtl/contador_limite.sv
// Modulo-LIMITE up-counter with synchronous clear; fim flags the last count.
module contador_limite #(
  parameter int WIDTH  = 4,
  parameter int LIMITE = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  logic [WIDTH-1:0] valor;

  assign fim = (valor == WIDTH'(LIMITE - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      valor <= '0;
    else if (zera)  valor <= '0;
    else if (conta) valor <= fim ? '0 : valor + WIDTH'(1);
  end

endmodule

// File: rtl/unidade_controle_param.sv
// Control unit for the memory/hit game: rounds, hit counting, LED blinking and
// per-round timeout. Define UC_PAUSA_EN to add the pausa freeze input.
module unidade_controle_param
  import uc_param_pkg::*;
#(
  parameter int N_SEQ      = N_SEQ_PADRAO,
  parameter int N_ACERTOS  = N_ACERTOS_PADRAO,
  parameter int N_PISCADAS = N_PISCADAS_PADRAO,
  parameter int T_ON       = T_ON_PADRAO,
  parameter int T_OFF      = T_OFF_PADRAO,
  parameter int T_LIMITE   = T_LIMITE_PADRAO
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          jogar,
  input  logic                          confirma,
  input  logic                          tem_jogada,
  input  logic                          acertouJogada,
  input  logic                          jogadaRepetida,
`ifdef UC_PAUSA_EN
  input  logic                          pausa,
`endif
  output logic                          zeraR,
  output logic                          registraR,
  output logic                          registraA,
  output logic                          zeraA,
  output logic                          registraL,
  output logic                          leds_on,
  output logic                          pronto,
  output logic                          acertou,
  output logic                          timeout_out,
  output logic [1:0]                    displayAddr,
  output logic                          displayFromMem,
  output logic [larguraPara(N_SEQ)-1:0] rodada,
  output logic [3:0]                    acertos,
  output logic [3:0]                    db_estado
);

  localparam int RW = larguraPara(N_SEQ);

  estado_t estado, proximo;
  logic    pausado, ativo, emRodada;
  logic    fimTimeout, fimOn, fimOff, fimPiscadas;

`ifdef UC_PAUSA_EN
  assign pausado = pausa;
`else
  assign pausado = 1'b0;
`endif
  assign ativo = ~pausado;

  // States in which the round timeout is armed and may preempt the FSM.
  assign emRodada = estado inside {inicia_rodada, espera_jogada, registra, comparacao,
                                   conta_acerto, pisca_on, pisca_off, testa_fim,
                                   proxima_rodada};

  // Also cleared in preparacao so a stale count from a timed-out game cannot fire in inicia_rodada.
  contador_limite #(.WIDTH(larguraPara(T_LIMITE)), .LIMITE(T_LIMITE)) contTimeout (
    .clock(clock), .reset(reset),
    .zera (ativo && (estado == preparacao || estado == inicia_rodada)),
    .conta(ativo && emRodada && estado != inicia_rodada),
    .fim  (fimTimeout)
  );

  contador_limite #(.WIDTH(larguraPara(T_ON)), .LIMITE(T_ON)) contOn (
    .clock(clock), .reset(reset),
    .zera (ativo && estado != pisca_on),
    .conta(ativo && estado == pisca_on),
    .fim  (fimOn)
  );

  contador_limite #(.WIDTH(larguraPara(T_OFF)), .LIMITE(T_OFF)) contOff (
    .clock(clock), .reset(reset),
    .zera (ativo && estado != pisca_off),
    .conta(ativo && estado == pisca_off),
    .fim  (fimOff)
  );

  contador_limite #(.WIDTH(larguraPara(N_PISCADAS)), .LIMITE(N_PISCADAS)) contPiscadas (
    .clock(clock), .reset(reset),
    .zera (ativo && estado == conta_acerto),
    .conta(ativo && estado == pisca_off && fimOff),
    .fim  (fimPiscadas)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      estado <= inicial;
    else if (ativo) estado <= proximo;
  end

  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    proximo = estado;
    case (estado)
      inicial:          if (jogar) proximo = preparacao;
      preparacao:       if (confirma) proximo = inicia_rodada;
      inicia_rodada:    proximo = espera_jogada;
      espera_jogada:    if (tem_jogada) proximo = registra;
      registra:         proximo = comparacao;
      comparacao:       proximo = (!acertouJogada || jogadaRepetida) ? espera_jogada : conta_acerto;
      conta_acerto:     proximo = (acertos == 4'(N_ACERTOS - 1)) ? pisca_on : espera_jogada;
      pisca_on:         if (fimOn) proximo = pisca_off;
      pisca_off:        if (fimOff) proximo = fimPiscadas ? testa_fim : pisca_on;
      testa_fim:        proximo = (rodada == RW'(N_SEQ - 1)) ? final_com_acerto : proxima_rodada;
      proxima_rodada:   proximo = inicia_rodada;
      final_com_acerto,
      estado_timeout:   if (jogar) proximo = preparacao;
      default:          proximo = inicial;
    endcase
    if (emRodada && fimTimeout) proximo = estado_timeout;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acertos <= '0;
      rodada  <= '0;
    end else if (ativo) begin
      if (estado == preparacao || estado == inicia_rodada)
        acertos <= '0;
      else if (estado == conta_acerto && acertos != 4'(N_ACERTOS))
        acertos <= acertos + 4'd1;

      if (estado == preparacao)
        rodada <= '0;
      else if (estado == proxima_rodada && rodada != RW'(N_SEQ - 1))
        rodada <= rodada + RW'(1);
    end
  end

  always_comb begin
    zeraR       = 1'b0;
    registraR   = 1'b0;
    registraA   = 1'b0;
    zeraA       = 1'b0;
    registraL   = 1'b0;
    pronto      = 1'b0;
    acertou     = 1'b0;
    timeout_out = 1'b0;
    case (estado)
      preparacao:       begin zeraR = 1'b1; zeraA = 1'b1; end
      inicia_rodada:    begin zeraA = 1'b1; registraL = 1'b1; end
      espera_jogada,
      testa_fim:        zeraR = 1'b1;
      registra:         registraR = 1'b1;
      conta_acerto:     registraA = 1'b1;
      final_com_acerto: begin zeraR = 1'b1; pronto = 1'b1; acertou = 1'b1; end
      estado_timeout:   begin zeraR = 1'b1; pronto = 1'b1; timeout_out = 1'b1; end
      default: ;
    endcase
    if (pausado) begin
      {zeraR, registraR, registraA, zeraA, registraL, pronto, acertou, timeout_out} = '0;
    end
  end

  // LEDs are forced dark while reset is held, even though inicial lights them.
  assign leds_on        = !reset && (estado != pisca_off);
  assign displayFromMem = estado inside {preparacao, final_com_acerto, estado_timeout};
  assign displayAddr    = (estado == preparacao)       ? DISP_PREPARACAO :
                          (estado == final_com_acerto) ? DISP_ACERTO     :
                          (estado == estado_timeout)   ? DISP_TIMEOUT    : DISP_JOGO;
  assign db_estado      = estado;

endmodule

// File: tb/tb_unidade_controle_param.sv
// Directed bench for unidade_controle_param with small parameters; the pause
// scenario runs only when UC_PAUSA_EN is defined.
module tb_unidade_controle_param;

  logic       clock = 1'b0, reset = 1'b1;
  logic       jogar = 1'b0, confirma = 1'b0, tem_jogada = 1'b0;
  logic       acertouJogada = 1'b0, jogadaRepetida = 1'b0;
`ifdef UC_PAUSA_EN
  logic       pausa = 1'b0;
`endif
  logic       zeraR, registraR, registraA, zeraA, registraL, leds_on;
  logic       pronto, acertou, timeout_out, displayFromMem;
  logic [1:0] displayAddr;
  logic [0:0] rodada;
  logic [3:0] acertos, db_estado;

  int nComparadas = 0;
  int nFalhas     = 0;
  int k;

  unidade_controle_param #(
    .N_SEQ(2), .N_ACERTOS(2), .N_PISCADAS(2), .T_ON(4), .T_OFF(4), .T_LIMITE(64)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .confirma(confirma),
    .tem_jogada(tem_jogada), .acertouJogada(acertouJogada), .jogadaRepetida(jogadaRepetida),
`ifdef UC_PAUSA_EN
    .pausa(pausa),
`endif
    .zeraR(zeraR), .registraR(registraR), .registraA(registraA), .zeraA(zeraA),
    .registraL(registraL), .leds_on(leds_on), .pronto(pronto), .acertou(acertou),
    .timeout_out(timeout_out), .displayAddr(displayAddr), .displayFromMem(displayFromMem),
    .rodada(rodada), .acertos(acertos), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nComparadas++;
    assert (obs === exp) else begin
      nFalhas++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  // Presents one play in espera_jogada and stops one cycle after comparacao.
  task automatic jogada(input logic hit, input logic rep);
    tem_jogada = 1'b1; acertouJogada = hit; jogadaRepetida = rep;
    ciclo();
    tem_jogada = 1'b0;
    check("registra_state", db_estado, 4'h4);
    check("registraR", registraR, 1'b1);
    ciclo();
    check("comparacao_state", db_estado, 4'h5);
    ciclo();
  endtask

  // From the first pisca_on cycle, run to testa_fim measuring the dark runs.
  task automatic piscar();
    int baixo, runs;
    baixo = 0; runs = 0;
    for (int i = 0; i < 60 && db_estado != 4'h9; i++) begin
      ciclo();
      if (!leds_on) baixo++;
      else if (baixo != 0) begin
        check("dark_run_len", baixo, 4);
        runs++;
        baixo = 0;
      end
    end
    check("dark_runs", runs, 2);
    check("testa_fim_state", db_estado, 4'h9);
  endtask

  task automatic medeTimeout(output int n);
    n = 0;
    while (db_estado == 4'h3 && n < 200) begin
      ciclo();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("rst_estado", db_estado, 4'h0);
    check("rst_displayAddr", displayAddr, 2'b11);
    check("rst_leds", leds_on, 1'b0);
    check("rst_strobes", {zeraR, registraR, registraA, zeraA, registraL}, 5'b0);
    check("rst_flags", {pronto, acertou, timeout_out, displayFromMem}, 4'b0);
    check("rst_counters", {rodada, acertos}, 5'b0);

    reset = 1'b0;
    confirma = 1'b1; ciclo(); confirma = 1'b0;
    check("confirma_ignored", db_estado, 4'h0);

    jogar = 1'b1; ciclo(); jogar = 1'b0;
    check("prep_state", db_estado, 4'h1);
    check("prep_zeros", {zeraR, zeraA}, 2'b11);
    check("prep_display", {displayFromMem, displayAddr}, 3'b100);
    tem_jogada = 1'b1; ciclo(); tem_jogada = 1'b0;
    check("tem_jogada_ignored", db_estado, 4'h1);

    confirma = 1'b1; ciclo(); confirma = 1'b0;
    check("inicia_state", db_estado, 4'h2);
    check("inicia_regL_zeraA", {registraL, zeraA}, 2'b11);
    ciclo();
    check("espera_state", db_estado, 4'h3);
    check("espera_zeraR", zeraR, 1'b1);

    // Round 0: hit, repeated hit, hit.
    jogada(1'b1, 1'b0);
    check("conta_state", db_estado, 4'h6);
    check("conta_registraA", registraA, 1'b1);
    ciclo();
    check("back_to_espera", db_estado, 4'h3);
    check("acertos_1", acertos, 4'd1);
    jogada(1'b1, 1'b1);
    check("repetida_state", db_estado, 4'h3);
    check("repetida_acertos", acertos, 4'd1);
    check("repetida_no_regA", registraA, 1'b0);
    jogada(1'b1, 1'b0);
    check("conta2_state", db_estado, 4'h6);
    ciclo();
    check("pisca_on_state", db_estado, 4'h8);
    check("acertos_2", acertos, 4'd2);
    check("pisca_on_leds", leds_on, 1'b1);
    piscar();
    check("testa_fim_rodada", rodada, 1'b0);
    check("testa_fim_zeraR", zeraR, 1'b1);
    ciclo();
    check("proxima_state", db_estado, 4'hB);
    ciclo();
    check("inicia2_state", db_estado, 4'h2);
    check("rodada_1", rodada, 1'b1);
    ciclo();
    check("acertos_cleared", acertos, 4'd0);

    // Round 1: miss, then two hits, then win.
    jogada(1'b0, 1'b0);
    check("miss_state", db_estado, 4'h3);
    check("miss_acertos", acertos, 4'd0);
    jogada(1'b1, 1'b0); ciclo();
    jogada(1'b1, 1'b0); ciclo();
    check("pisca_on2_state", db_estado, 4'h8);
    piscar();
    ciclo();
    check("final_state", db_estado, 4'hA);
    check("final_flags", {pronto, acertou, timeout_out}, 3'b110);
    check("final_rodada", rodada, 1'b1);
    check("final_display", {displayFromMem, displayAddr}, 3'b101);

    jogar = 1'b1; ciclo(); jogar = 1'b0;
    check("replay_state", db_estado, 4'h1);
    ciclo();
    check("replay_rodada", rodada, 1'b0);

    // Timeout: idle in espera_jogada.
    confirma = 1'b1; ciclo(); confirma = 1'b0;
    ciclo();
    check("to_espera", db_estado, 4'h3);
    medeTimeout(k);
    check("timeout_cycles", k, 64);
    check("timeout_state", db_estado, 4'hE);
    check("timeout_flags", {pronto, acertou, timeout_out}, 3'b101);
    check("timeout_display", displayAddr, 2'b10);
    jogar = 1'b1; ciclo(); jogar = 1'b0;
    check("timeout_jogar", db_estado, 4'h1);

    // Reset in the middle of pisca_on.
    confirma = 1'b1; ciclo(); confirma = 1'b0;
    ciclo();
    jogada(1'b1, 1'b0); ciclo();
    jogada(1'b1, 1'b0); ciclo();
    check("pre_reset_state", db_estado, 4'h8);
    ciclo(); ciclo();
    reset = 1'b1;
    #1;
    check("async_reset_state", db_estado, 4'h0);
    ciclo();
    check("reset_state", db_estado, 4'h0);
    check("reset_counters", {rodada, acertos}, 5'b0);
    check("reset_outputs", {leds_on, pronto, zeraR, displayAddr}, 5'b00011);
    reset = 1'b0;
    ciclo();

`ifdef UC_PAUSA_EN
    jogar = 1'b1; ciclo(); jogar = 1'b0;
    confirma = 1'b1; ciclo(); confirma = 1'b0;
    ciclo();
    check("pausa_espera", db_estado, 4'h3);
    pausa = 1'b1;
    repeat (100) ciclo();
    check("pausa_state", db_estado, 4'h3);
    check("pausa_no_timeout", timeout_out, 1'b0);
    check("pausa_strobes", zeraR, 1'b0);
    check("pausa_leds_display", {leds_on, displayAddr}, 3'b111);
    pausa = 1'b0;
    medeTimeout(k);
    check("pausa_timer_held", k, 64);
    check("pausa_then_timeout", db_estado, 4'hE);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComparadas, nFalhas);
    $finish;
  end

endmodule
